// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side and RAM-side signal bundle of ram_port_arbiter
interface ram_port_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int AW    = 16
);
    logic [N_REQ-1:0]    req_i;
    logic [4*N_REQ-1:0]  we_i;
    logic [AW*N_REQ-1:0] addr_i;
    logic [32*N_REQ-1:0] wdata_i;
    logic [N_REQ-1:0]    gnt_o;
    logic [N_REQ-1:0]    rvalid_o;
    logic [31:0]         rdata_o;
    logic                mem_en_o;
    logic [3:0]          mem_we_o;
    logic [AW-1:0]       mem_addr_o;
    logic [31:0]         mem_data_o;
    logic [31:0]         mem_data_i;
    logic [32*N_REQ-1:0] grant_cnt_o;
    logic [32*N_REQ-1:0] wait_cnt_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, mem_data_i,
        output gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
               grant_cnt_o, wait_cnt_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, mem_data_i,
        input  gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
               grant_cnt_o, wait_cnt_o
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin sharing of one RAM port; define RAM_ARB_STATS_EN for grant/wait counters
module ram_port_arbiter #(
    parameter int MEM_WIDTH = 65536,
    parameter int N_REQ     = 2
) (
    input  logic              clk,
    input  logic              reset,
    ram_port_arbiter_if.slave bus
);
    localparam int AW = $clog2(MEM_WIDTH);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic             found;
    logic [N_REQ-1:0] gnt;
    int               idx;
    logic             rd_grant;
    logic             rsp_valid;
    logic [PW-1:0]    rsp_owner;

    // Search starts at ptr and wraps; reset masks every grant.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = (int'(ptr) + i) % N_REQ;
                if (!found && bus.req_i[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    win      = PW'(idx);
                end
            end
        end
    end

    always_comb begin
        bus.gnt_o      = gnt;
        bus.mem_en_o   = found;
        bus.mem_we_o   = 4'b0000;
        bus.mem_addr_o = '0;
        bus.mem_data_o = 32'h0;
        if (found) begin
            bus.mem_we_o   = bus.we_i[4*int'(win) +: 4];
            bus.mem_addr_o = bus.addr_i[AW*int'(win) +: AW];
            bus.mem_data_o = bus.wdata_i[32*int'(win) +: 32];
        end
    end

    assign rd_grant = found && (bus.mem_we_o == 4'b0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_owner <= '0;
        end else begin
            if (found) begin
                ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
            end
            rsp_valid <= rd_grant;
            if (rd_grant) begin
                rsp_owner <= win;
            end
        end
    end

    // Read data is gated by the response flag so a stale RAM word never leaks out.
    always_comb begin
        bus.rvalid_o = '0;
        bus.rdata_o  = 32'h0;
        if (rsp_valid && !reset) begin
            bus.rvalid_o[rsp_owner] = 1'b1;
            bus.rdata_o             = bus.mem_data_i;
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [32*N_REQ-1:0] grant_cnt;
    logic [32*N_REQ-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (gnt[k] && (grant_cnt[32*k +: 32] != 32'hFFFF_FFFF)) begin
                    grant_cnt[32*k +: 32] <= grant_cnt[32*k +: 32] + 32'd1;
                end
                if (bus.req_i[k] && !gnt[k] && (wait_cnt[32*k +: 32] != 32'hFFFF_FFFF)) begin
                    wait_cnt[32*k +: 32] <= wait_cnt[32*k +: 32] + 32'd1;
                end
            end
        end
    end

    assign bus.grant_cnt_o = grant_cnt;
    assign bus.wait_cnt_o  = wait_cnt;
`else
    assign bus.grant_cnt_o = '0;
    assign bus.wait_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter with a byte-array RAM and reference model
module tb_ram_port_arbiter;
    localparam int MEM_WIDTH = 65536;
    localparam int N_REQ     = 3;
    localparam int AW        = $clog2(MEM_WIDTH);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.N_REQ(N_REQ), .AW(AW)) bus ();
    ram_port_arbiter #(.MEM_WIDTH(MEM_WIDTH), .N_REQ(N_REQ)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Simulation RAM: registered read, byte-lane writes at addr+0..3
    logic [7:0] ram    [MEM_WIDTH];
    logic [7:0] shadow [MEM_WIDTH];

    function automatic logic [31:0] ram_word(int a);
        return {ram[(a+3)%MEM_WIDTH], ram[(a+2)%MEM_WIDTH], ram[(a+1)%MEM_WIDTH], ram[a%MEM_WIDTH]};
    endfunction

    function automatic logic [31:0] shadow_word(int a);
        return {shadow[(a+3)%MEM_WIDTH], shadow[(a+2)%MEM_WIDTH], shadow[(a+1)%MEM_WIDTH], shadow[a%MEM_WIDTH]};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we_o[b]) ram[(int'(bus.mem_addr_o)+b)%MEM_WIDTH] <= bus.mem_data_o[8*b +: 8];
            end
            bus.mem_data_i <= ram_word(int'(bus.mem_addr_o));
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    int          m_ptr, m_pend, m_owner, exp_k;
    int          m_gcnt [N_REQ];
    int          m_wcnt [N_REQ];
    logic [31:0] m_pend_data;

    logic [N_REQ-1:0]    exp_gnt, exp_rvalid;
    logic                exp_en;
    logic [3:0]          exp_we;
    logic [AW-1:0]       exp_addr;
    logic [31:0]         exp_data, exp_rdata;
    logic [32*N_REQ-1:0] exp_gcnt, exp_wcnt;

    task automatic compute_expect();
        exp_k = -1;
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                int j;
                j = (m_ptr + i) % N_REQ;
                if (exp_k < 0 && bus.req_i[j]) exp_k = j;
            end
        end
        exp_gnt = '0; exp_en = 1'b0; exp_we = 4'b0; exp_addr = '0; exp_data = 32'h0;
        if (exp_k >= 0) begin
            exp_gnt[exp_k] = 1'b1;
            exp_en         = 1'b1;
            exp_we         = bus.we_i[4*exp_k +: 4];
            exp_addr       = bus.addr_i[AW*exp_k +: AW];
            exp_data       = bus.wdata_i[32*exp_k +: 32];
        end
        exp_rvalid = '0; exp_rdata = 32'h0;
        if (m_pend != 0 && !reset) begin
            exp_rvalid[m_owner] = 1'b1;
            exp_rdata           = m_pend_data;
        end
        for (int k = 0; k < N_REQ; k++) begin
`ifdef RAM_ARB_STATS_EN
            exp_gcnt[32*k +: 32] = 32'(m_gcnt[k]);
            exp_wcnt[32*k +: 32] = 32'(m_wcnt[k]);
`else
            exp_gcnt[32*k +: 32] = 32'h0;
            exp_wcnt[32*k +: 32] = 32'h0;
`endif
        end
    endtask

    task automatic settle();
        #1;
        compute_expect();
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_pend = 0;
            for (int k = 0; k < N_REQ; k++) begin m_gcnt[k] = 0; m_wcnt[k] = 0; end
        end else begin
            for (int k = 0; k < N_REQ; k++) if (bus.req_i[k] && k != exp_k) m_wcnt[k]++;
            m_pend = 0;
            if (exp_k >= 0) begin
                m_gcnt[exp_k]++;
                m_ptr = (exp_k + 1) % N_REQ;
                if (exp_we == 4'b0000) begin
                    m_pend = 1; m_owner = exp_k; m_pend_data = shadow_word(int'(exp_addr));
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (exp_we[b]) shadow[(int'(exp_addr)+b)%MEM_WIDTH] = exp_data[8*b +: 8];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1; clear_inputs();
        settle(); tick();
        reset = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_inputs(); bus.req_i = '1;
        settle();
        n_cmp++; if (bus.gnt_o !== '0) begin n_fail++; $display("FAIL rst_hold_gnt got %b want 0", bus.gnt_o); end
        n_cmp++; if (bus.mem_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_hold_en got %b want 0", bus.mem_en_o); end
        tick(); settle(); tick();
        reset = 1'b0; bus.req_i = '0;
        settle();
        n_cmp++; if (bus.gnt_o !== '0) begin n_fail++; $display("FAIL rst_gnt got %b want 0", bus.gnt_o); end
        n_cmp++; if (bus.rvalid_o !== '0) begin n_fail++; $display("FAIL rst_rvalid got %b want 0", bus.rvalid_o); end
        n_cmp++; if (bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", bus.rdata_o); end
        n_cmp++; if ({bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o} !== '0) begin n_fail++; $display("FAIL rst_mem got %b/%b/%h/%h want all 0", bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o); end
        n_cmp++; if ({bus.grant_cnt_o, bus.wait_cnt_o} !== '0) begin n_fail++; $display("FAIL rst_cnt got %h/%h want 0", bus.grant_cnt_o, bus.wait_cnt_o); end
    endtask

    task automatic test_single_read();
        bus.req_i = 3'b001; bus.we_i = '0; bus.addr_i[0 +: AW] = 16'h0010;
        settle();
        n_cmp++; if (bus.gnt_o !== 3'b001) begin n_fail++; $display("FAIL rd1_gnt got %b want 001", bus.gnt_o); end
        n_cmp++; if (bus.mem_en_o !== 1'b1) begin n_fail++; $display("FAIL rd1_en got %b want 1", bus.mem_en_o); end
        n_cmp++; if (bus.mem_addr_o !== 16'h0010) begin n_fail++; $display("FAIL rd1_addr got %h want 0010", bus.mem_addr_o); end
        n_cmp++; if (bus.mem_we_o !== 4'b0000) begin n_fail++; $display("FAIL rd1_we got %b want 0000", bus.mem_we_o); end
        tick();
        bus.req_i = '0;
        settle();
        n_cmp++; if (bus.rvalid_o !== 3'b001) begin n_fail++; $display("FAIL rd1_rvalid got %b want 001", bus.rvalid_o); end
        n_cmp++; if (bus.rdata_o !== exp_rdata) begin n_fail++; $display("FAIL rd1_rdata got %h want %h", bus.rdata_o, exp_rdata); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] seq [4] = '{3'b001, 3'b010, 3'b001, 3'b010};
        apply_reset();
        bus.req_i = 3'b011; bus.we_i = '0;
        bus.addr_i[0 +: AW] = 16'h0200; bus.addr_i[AW +: AW] = 16'h0301;
        for (int c = 0; c < 4; c++) begin
            settle();
            n_cmp++; if (bus.gnt_o !== seq[c]) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b want %b", c, bus.gnt_o, seq[c]); end
            n_cmp++; if (bus.rvalid_o !== ((c == 0) ? 3'b000 : seq[(c+3)%4])) begin n_fail++; $display("FAIL rr_rvalid[%0d] got %b", c, bus.rvalid_o); end
            n_cmp++; if (bus.rdata_o !== exp_rdata) begin n_fail++; $display("FAIL rr_rdata[%0d] got %h want %h", c, bus.rdata_o, exp_rdata); end
            tick();
        end
        bus.req_i = '0;
        settle();
        n_cmp++; if (bus.rvalid_o !== 3'b010) begin n_fail++; $display("FAIL rr_rvalid_last got %b want 010", bus.rvalid_o); end
        tick();
    endtask

    task automatic test_partial_write();
        bus.req_i = 3'b010; bus.we_i[4 +: 4] = 4'b0011; bus.wdata_i[32 +: 32] = 32'hA5A5_1234;
        bus.addr_i[AW +: AW] = 16'h0100;
        settle();
        n_cmp++; if (bus.gnt_o !== 3'b010) begin n_fail++; $display("FAIL wr_gnt got %b want 010", bus.gnt_o); end
        n_cmp++; if (bus.mem_we_o !== 4'b0011) begin n_fail++; $display("FAIL wr_we got %b want 0011", bus.mem_we_o); end
        n_cmp++; if (bus.mem_data_o !== 32'hA5A5_1234) begin n_fail++; $display("FAIL wr_data got %h want a5a51234", bus.mem_data_o); end
        n_cmp++; if (bus.mem_addr_o !== 16'h0100) begin n_fail++; $display("FAIL wr_addr got %h want 0100", bus.mem_addr_o); end
        tick();
        bus.req_i = '0;
        settle();
        n_cmp++; if (bus.rvalid_o !== 3'b000) begin n_fail++; $display("FAIL wr_rvalid got %b want 000", bus.rvalid_o); end
        bus.req_i = 3'b001; bus.we_i[0 +: 4] = 4'b0000; bus.addr_i[0 +: AW] = 16'h0100;
        settle();
        tick();
        bus.req_i = '0;
        settle();
        n_cmp++; if (bus.rvalid_o !== 3'b001) begin n_fail++; $display("FAIL wrrd_rvalid got %b want 001", bus.rvalid_o); end
        n_cmp++; if (bus.rdata_o[15:0] !== 16'h1234) begin n_fail++; $display("FAIL wrrd_low got %h want 1234", bus.rdata_o[15:0]); end
        n_cmp++; if (bus.rdata_o !== exp_rdata) begin n_fail++; $display("FAIL wrrd_word got %h want %h", bus.rdata_o, exp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        bus.req_i = 3'b001; bus.addr_i[0 +: AW] = 16'h0040;
        settle();
        n_cmp++; if (bus.gnt_o !== 3'b001) begin n_fail++; $display("FAIL rm_gnt got %b want 001", bus.gnt_o); end
        tick();
        reset = 1'b1;
        settle();
        n_cmp++; if (bus.rvalid_o !== 3'b000) begin n_fail++; $display("FAIL rm_rvalid got %b want 000", bus.rvalid_o); end
        n_cmp++; if (bus.gnt_o !== 3'b000) begin n_fail++; $display("FAIL rm_gnt_rst got %b want 000", bus.gnt_o); end
        n_cmp++; if (bus.mem_en_o !== 1'b0 || bus.mem_we_o !== 4'b0) begin n_fail++; $display("FAIL rm_mem got en=%b we=%b want 0", bus.mem_en_o, bus.mem_we_o); end
        tick();
        reset = 1'b0; bus.req_i = 3'b011; bus.addr_i[AW +: AW] = 16'h0080;
        settle();
        n_cmp++; if (bus.gnt_o !== 3'b001) begin n_fail++; $display("FAIL rm_first_gnt got %b want 001", bus.gnt_o); end
        n_cmp++; if (bus.rvalid_o !== 3'b000) begin n_fail++; $display("FAIL rm_rvalid_after got %b want 000", bus.rvalid_o); end
        tick();
    endtask

    task automatic test_three_way();
        logic [N_REQ-1:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        int want_g, want_w;
`ifdef RAM_ARB_STATS_EN
        want_g = 2; want_w = 4;
`else
        want_g = 0; want_w = 0;
`endif
        apply_reset();
        bus.req_i = 3'b111; bus.we_i = '0;
        for (int k = 0; k < N_REQ; k++) bus.addr_i[AW*k +: AW] = AW'(16'h1000 + 4*k);
        for (int c = 0; c < 6; c++) begin
            settle();
            n_cmp++; if (bus.gnt_o !== seq[c]) begin n_fail++; $display("FAIL rr3_gnt[%0d] got %b want %b", c, bus.gnt_o, seq[c]); end
            n_cmp++; if (bus.grant_cnt_o !== exp_gcnt || bus.wait_cnt_o !== exp_wcnt) begin n_fail++; $display("FAIL rr3_cnt[%0d] got %h/%h want %h/%h", c, bus.grant_cnt_o, bus.wait_cnt_o, exp_gcnt, exp_wcnt); end
            tick();
        end
        bus.req_i = '0;
        settle();
        for (int k = 0; k < N_REQ; k++) begin
            n_cmp++; if (bus.grant_cnt_o[32*k +: 32] !== 32'(want_g)) begin n_fail++; $display("FAIL rr3_grant_cnt[%0d] got %0d want %0d", k, bus.grant_cnt_o[32*k +: 32], want_g); end
            n_cmp++; if (bus.wait_cnt_o[32*k +: 32] !== 32'(want_w)) begin n_fail++; $display("FAIL rr3_wait_cnt[%0d] got %0d want %0d", k, bus.wait_cnt_o[32*k +: 32], want_w); end
        end
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!bus.req_i[k] || exp_k == k) begin
                    if ($urandom_range(0, 3) != 0) begin
                        bus.req_i[k]             = 1'b1;
                        bus.we_i[4*k +: 4]       = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
                        bus.addr_i[AW*k +: AW]   = AW'($urandom);
                        bus.wdata_i[32*k +: 32]  = $urandom;
                    end else begin
                        bus.req_i[k] = 1'b0;
                    end
                end
            end
            settle();
            n_cmp++; if (bus.gnt_o !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt[%0d] got %b want %b", c, bus.gnt_o, exp_gnt); end
            n_cmp++; if ({bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o} !== {exp_en, exp_we, exp_addr, exp_data}) begin n_fail++; $display("FAIL rnd_mem[%0d] got %b/%b/%h/%h want %b/%b/%h/%h", c, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o, exp_en, exp_we, exp_addr, exp_data); end
            n_cmp++; if (bus.rvalid_o !== exp_rvalid) begin n_fail++; $display("FAIL rnd_rvalid[%0d] got %b want %b", c, bus.rvalid_o, exp_rvalid); end
            n_cmp++; if (bus.rdata_o !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d] got %h want %h", c, bus.rdata_o, exp_rdata); end
            n_cmp++; if (bus.grant_cnt_o !== exp_gcnt || bus.wait_cnt_o !== exp_wcnt) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %h/%h want %h/%h", c, bus.grant_cnt_o, bus.wait_cnt_o, exp_gcnt, exp_wcnt); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WIDTH; i++) begin
            ram[i]    = 8'(i ^ (i >> 8) ^ 8'h5A);
            shadow[i] = 8'(i ^ (i >> 8) ^ 8'h5A);
        end
        m_ptr = 0; m_pend = 0; m_owner = 0; exp_k = -1; m_pend_data = 32'h0;
        for (int k = 0; k < N_REQ; k++) begin m_gcnt[k] = 0; m_wcnt[k] = 0; end
        test_reset();
        test_single_read();
        test_round_robin();
        test_partial_write();
        test_reset_mid();
        test_three_way();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
